// File: rtl/hms_pkg.sv
// Shared types and constants for the HH:MM:SS timekeeper.
// HMS_TIMEKEEPER_ALARM_EN adds the two alarm-setup states.
package hms_pkg;

    localparam int unsigned FIELD_W = 6;
    localparam int unsigned SEC_MAX = 59;
    localparam int unsigned MIN_MAX = 59;

    localparam logic [1:0] POS_SEC  = 2'b00;
    localparam logic [1:0] POS_MIN  = 2'b01;
    localparam logic [1:0] POS_HOUR = 2'b10;
    localparam logic [1:0] POS_AL   = 2'b11;

`ifdef HMS_TIMEKEEPER_ALARM_EN
    typedef enum logic [2:0] {
        ST_CLOCK,
        ST_SET_SEC,
        ST_SET_MIN,
        ST_SET_HOUR,
        ST_SET_AL_MIN,
        ST_SET_AL_HOUR
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_CLOCK,
        ST_SET_SEC,
        ST_SET_MIN,
        ST_SET_HOUR
    } state_e;
`endif

    // Increment with wrap to zero after the field's last legal value.
    function automatic logic [FIELD_W-1:0] wrap_inc(input logic [FIELD_W-1:0] v,
                                                    input logic [FIELD_W-1:0] max);
        return (v >= max) ? '0 : v + FIELD_W'(1);
    endfunction

endpackage

// File: rtl/btn_pulse.sv
// Button conditioner: 2-flop synchroniser, strobe-sampled two-sample debounce,
// one-cycle press pulse. A button held through reset must be released before it can fire.
module btn_pulse (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_i,
    input  logic btn_n_i,
    output logic press_o
);

    logic [1:0] sync_q;
    logic       smp_q;
    logic       stable_q;
    logic       armed_q;
    logic       press_q;

    // stable_q is the debounced level (1 = released); armed_q needs one real high sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= 2'b11;
            smp_q    <= 1'b1;
            stable_q <= 1'b1;
            armed_q  <= 1'b0;
            press_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_n_i};
            press_q <= 1'b0;
            if (sample_i) begin
                smp_q <= sync_q[1];
                if (sync_q[1]) begin
                    armed_q <= 1'b1;
                end
                if (stable_q && armed_q && !smp_q && !sync_q[1]) begin
                    stable_q <= 1'b0;
                    press_q  <= 1'b1;
                end else if (!stable_q && smp_q && sync_q[1]) begin
                    stable_q <= 1'b1;
                end
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/hms_timekeeper.sv
// Single-clock HH:MM:SS timekeeper with button-driven setup FSM.
// Optional alarm fields and states are enabled by HMS_TIMEKEEPER_ALARM_EN.
module hms_timekeeper
    import hms_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50000000,
    parameter int unsigned DEB_HZ    = 100,
    parameter int unsigned HOUR_MAX  = 23,
    parameter int unsigned BLINK_DIV = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_sw_mode,
    input  logic               i_sw_pos,
    input  logic               i_sw_inc,
    output logic [FIELD_W-1:0] o_sec,
    output logic [FIELD_W-1:0] o_min,
    output logic [FIELD_W-1:0] o_hour,
    output logic               o_mode,
    output logic [1:0]         o_position,
    output logic               o_blink,
`ifdef HMS_TIMEKEEPER_ALARM_EN
    output logic               o_tick,
    output logic               o_alarm,
    output logic [FIELD_W-1:0] o_al_min,
    output logic [FIELD_W-1:0] o_al_hour
`else
    output logic               o_tick
`endif
);

    localparam int unsigned DEB_DIV = CLK_HZ / DEB_HZ;
    localparam int unsigned BLK_DIV = CLK_HZ / BLINK_DIV;
    localparam int unsigned PRE_W   = $clog2(CLK_HZ);
    localparam int unsigned DEB_W   = $clog2(DEB_DIV);
    localparam int unsigned BLK_W   = $clog2(BLK_DIV);

    localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(CLK_HZ - 1);
    localparam logic [DEB_W-1:0]   DEB_LAST = DEB_W'(DEB_DIV - 1);
    localparam logic [BLK_W-1:0]   BLK_LAST = BLK_W'(BLK_DIV - 1);
    localparam logic [FIELD_W-1:0] SEC_LIM  = FIELD_W'(SEC_MAX);
    localparam logic [FIELD_W-1:0] MIN_LIM  = FIELD_W'(MIN_MAX);
    localparam logic [FIELD_W-1:0] HOUR_LIM = FIELD_W'(HOUR_MAX);

    state_e             state_q, state_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [DEB_W-1:0]   deb_q;
    logic               deb_stb_q;
    logic [BLK_W-1:0]   blk_q, blk_d;
    logic [FIELD_W-1:0] sec_q, sec_d, min_q, min_d, hour_q, hour_d;
    logic               mode_q, mode_d, blink_q, blink_d, tick_q, tick_d;
    logic [1:0]         pos_q, pos_d;
    logic               tick_c, mode_p, pos_p, inc_p, mode_c, pos_c, inc_c;
`ifdef HMS_TIMEKEEPER_ALARM_EN
    logic               alarm_q, alarm_d, al_arm_q, al_arm_d;
    logic [FIELD_W-1:0] al_cnt_q, al_cnt_d, al_min_q, al_min_d, al_hour_q, al_hour_d;
`endif

    // Shared debounce sampling strobe for all three buttons.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_q     <= '0;
            deb_stb_q <= 1'b0;
        end else if (deb_q == DEB_LAST) begin
            deb_q     <= '0;
            deb_stb_q <= 1'b1;
        end else begin
            deb_q     <= deb_q + DEB_W'(1);
            deb_stb_q <= 1'b0;
        end
    end

    btn_pulse u_btn_mode (.clk(clk), .rst_n(rst_n), .sample_i(deb_stb_q), .btn_n_i(i_sw_mode), .press_o(mode_p));
    btn_pulse u_btn_pos  (.clk(clk), .rst_n(rst_n), .sample_i(deb_stb_q), .btn_n_i(i_sw_pos),  .press_o(pos_p));
    btn_pulse u_btn_inc  (.clk(clk), .rst_n(rst_n), .sample_i(deb_stb_q), .btn_n_i(i_sw_inc),  .press_o(inc_p));

    assign tick_c = (pre_q == PRE_LAST);

    always_comb begin
        state_d = state_q;
        pre_d   = tick_c ? '0 : pre_q + PRE_W'(1);
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;
        tick_d  = 1'b0;
        blink_d = blink_q;
        blk_d   = blk_q;
        pos_d   = POS_SEC;
        mode_c  = mode_p;
        pos_c   = pos_p & ~mode_p;
        inc_c   = inc_p & ~mode_p & ~pos_p;
`ifdef HMS_TIMEKEEPER_ALARM_EN
        alarm_d   = alarm_q;
        al_arm_d  = al_arm_q;
        al_cnt_d  = al_cnt_q;
        al_min_d  = al_min_q;
        al_hour_d = al_hour_q;
        // A press while ringing only silences the alarm.
        if (alarm_q && (mode_p || pos_p || inc_p)) begin
            alarm_d = 1'b0;
            mode_c  = 1'b0;
            pos_c   = 1'b0;
            inc_c   = 1'b0;
        end else if (alarm_q && tick_c) begin
            if (al_cnt_q == FIELD_W'(59)) begin
                alarm_d = 1'b0;
            end else begin
                al_cnt_d = al_cnt_q + FIELD_W'(1);
            end
        end
`endif

        case (state_q)
            ST_CLOCK: begin
                if (tick_c) begin
                    tick_d = 1'b1;
                    sec_d  = wrap_inc(sec_q, SEC_LIM);
                    if (sec_q == SEC_LIM) begin
                        min_d = wrap_inc(min_q, MIN_LIM);
                        if (min_q == MIN_LIM) begin
                            hour_d = wrap_inc(hour_q, HOUR_LIM);
                        end
                    end
`ifdef HMS_TIMEKEEPER_ALARM_EN
                    if (al_arm_q && sec_d == '0 && min_d == al_min_q && hour_d == al_hour_q) begin
                        alarm_d  = 1'b1;
                        al_cnt_d = '0;
                    end
`endif
                end
                if (mode_c) begin
                    state_d = ST_SET_SEC;
                end
            end
            ST_SET_SEC: begin
                if (mode_c) begin
                    state_d = ST_CLOCK;
                end else if (pos_c) begin
                    state_d = ST_SET_MIN;
                end else if (inc_c) begin
                    sec_d = wrap_inc(sec_q, SEC_LIM);
                    pre_d = '0;
                end
            end
            ST_SET_MIN: begin
                if (mode_c) begin
                    state_d = ST_CLOCK;
                end else if (pos_c) begin
                    state_d = ST_SET_HOUR;
                end else if (inc_c) begin
                    min_d = wrap_inc(min_q, MIN_LIM);
                end
            end
            ST_SET_HOUR: begin
                if (mode_c) begin
                    state_d = ST_CLOCK;
                end else if (pos_c) begin
`ifdef HMS_TIMEKEEPER_ALARM_EN
                    state_d = ST_SET_AL_MIN;
`else
                    state_d = ST_SET_SEC;
`endif
                end else if (inc_c) begin
                    hour_d = wrap_inc(hour_q, HOUR_LIM);
                end
            end
`ifdef HMS_TIMEKEEPER_ALARM_EN
            ST_SET_AL_MIN: begin
                if (mode_c) begin
                    state_d = ST_CLOCK;
                end else if (pos_c) begin
                    state_d = ST_SET_AL_HOUR;
                end else if (inc_c) begin
                    al_min_d = wrap_inc(al_min_q, MIN_LIM);
                    al_arm_d = 1'b1;
                end
            end
            ST_SET_AL_HOUR: begin
                if (mode_c) begin
                    state_d = ST_CLOCK;
                end else if (pos_c) begin
                    state_d = ST_SET_SEC;
                end else if (inc_c) begin
                    al_hour_d = wrap_inc(al_hour_q, HOUR_LIM);
                    al_arm_d  = 1'b1;
                end
            end
`endif
            default: state_d = ST_CLOCK;
        endcase

        mode_d = (state_d != ST_CLOCK);
        case (state_d)
            ST_SET_MIN:     pos_d = POS_MIN;
            ST_SET_HOUR:    pos_d = POS_HOUR;
`ifdef HMS_TIMEKEEPER_ALARM_EN
            ST_SET_AL_MIN:  pos_d = POS_AL;
            ST_SET_AL_HOUR: pos_d = POS_AL;
`endif
            default:        pos_d = POS_SEC;
        endcase

        // Blink phase only runs while a field is being edited.
        if (state_d == ST_CLOCK) begin
            blink_d = 1'b0;
            blk_d   = '0;
        end else if (blk_q == BLK_LAST) begin
            blink_d = ~blink_q;
            blk_d   = '0;
        end else begin
            blk_d = blk_q + BLK_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLOCK;
            pre_q   <= '0;
            blk_q   <= '0;
            sec_q   <= '0;
            min_q   <= '0;
            hour_q  <= '0;
            mode_q  <= 1'b0;
            pos_q   <= POS_SEC;
            blink_q <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            blk_q   <= blk_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
            mode_q  <= mode_d;
            pos_q   <= pos_d;
            blink_q <= blink_d;
            tick_q  <= tick_d;
        end
    end

`ifdef HMS_TIMEKEEPER_ALARM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_q   <= 1'b0;
            al_arm_q  <= 1'b0;
            al_cnt_q  <= '0;
            al_min_q  <= '0;
            al_hour_q <= '0;
        end else begin
            alarm_q   <= alarm_d;
            al_arm_q  <= al_arm_d;
            al_cnt_q  <= al_cnt_d;
            al_min_q  <= al_min_d;
            al_hour_q <= al_hour_d;
        end
    end

    assign o_alarm   = alarm_q;
    assign o_al_min  = al_min_q;
    assign o_al_hour = al_hour_q;
`endif

    assign o_sec      = sec_q;
    assign o_min      = min_q;
    assign o_hour     = hour_q;
    assign o_mode     = mode_q;
    assign o_position = pos_q;
    assign o_blink    = blink_q;
    assign o_tick     = tick_q;

endmodule
